pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register, the successor of the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) in the pipelined RV32 core. It carries a control field and a data field between two stages with a valid/ready handshake, supports stall (back-pressure) and flush (bubble insertion), and zeroes control bits on reset or flush so that a bubble can never write memory, the register file or the PC. An optional skid buffer decouples `in_ready` from `out_ready` for timing closure.

---
 rtl/pipe_pkg.sv | 37 +++
 rtl/pipe_entry.sv | 52 +++++
 rtl/pipe_stage_reg.sv | 109 ++++++++++
 tb/tb_pipe_stage_reg.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: occupancy states, per-stage
// field widths and the ID/EX control-bit packing order.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } occ_state_t;

    // ID/EX control word, most significant field first
    typedef struct packed {
        logic       pc_load;
        logic       pc_reset;
        logic       mem_re;
        logic       mem_we;
        logic       reg_file_write;
        logic [1:0] alu_op;
        logic [1:0] select_mux_1;
        logic [1:0] select_mux_2;
        logic [1:0] select_mux_4;
    } idex_ctrl_t;

    localparam int IFID_CTRL_W  = 1;
    localparam int IFID_DATA_W  = 64;
    localparam int IDEX_CTRL_W  = $bits(idex_ctrl_t);
    localparam int IDEX_DATA_W  = 135;
    localparam int EXMEM_CTRL_W = 4;
    localparam int EXMEM_DATA_W = 101;
    localparam int MEMWB_CTRL_W = 2;
    localparam int MEMWB_DATA_W = 69;

    function automatic logic [IDEX_CTRL_W-1:0] pack_idex_ctrl(input idex_ctrl_t c);
        return c;
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// One pipeline slot: valid + control + data. Priority: clr_all > clr_ctrl > load;
// clr_ctrl empties the slot but keeps the data field.
module pipe_entry #(
    parameter int CTRL_W = 12,
    parameter int DATA_W = 135
) (
    input  logic              clk,
    input  logic              clr_all_i,
    input  logic              clr_ctrl_i,
    input  logic              load_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (clr_ctrl_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_i;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_all_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, stall and flush.
// Define PIPE_STAGE_SKID_EN to add a skid entry so in_ready is registered-only.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 12,
    parameter int DATA_W = 135
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
);

    logic accept;
    assign accept = in_valid && in_ready;

`ifdef PIPE_STAGE_SKID_EN
    // state | meaning
    // EMPTY | no beat held
    // FULL  | main entry holds the output beat
    // SKID  | main and skid entries both hold beats, input stalled
    occ_state_t        state_q;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              drain_skid;
    logic              main_load, main_clr, skid_load, skid_clr;
    logic [CTRL_W-1:0] main_ctrl_d;
    logic [DATA_W-1:0] main_data_d;

    assign in_ready   = !flush && (state_q != SKID);
    assign drain_skid = skid_valid && out_ready;

    always_comb begin
        main_load   = drain_skid || (accept && (!out_valid || out_ready));
        main_clr    = flush || (out_valid && out_ready && !accept && !skid_valid);
        main_ctrl_d = skid_valid ? skid_ctrl : in_ctrl;
        main_data_d = skid_valid ? skid_data : in_data;
        skid_load   = accept && out_valid && !out_ready;
        skid_clr    = flush || drain_skid;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q <= EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept) state_q <= FULL;
                FULL: begin
                    if (accept && !out_ready)      state_q <= SKID;
                    else if (!accept && out_ready) state_q <= EMPTY;
                end
                SKID:    if (out_ready) state_q <= FULL;
                default: state_q <= EMPTY;
            endcase
        end
    end

    pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk        (clk),
        .clr_all_i  (reset),
        .clr_ctrl_i (main_clr),
        .load_i     (main_load),
        .ctrl_i     (main_ctrl_d),
        .data_i     (main_data_d),
        .valid_o    (out_valid),
        .ctrl_o     (out_ctrl),
        .data_o     (out_data)
    );

    pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk        (clk),
        .clr_all_i  (reset),
        .clr_ctrl_i (skid_clr),
        .load_i     (skid_load),
        .ctrl_i     (in_ctrl),
        .data_i     (in_data),
        .valid_o    (skid_valid),
        .ctrl_o     (skid_ctrl),
        .data_o     (skid_data)
    );
`else
    logic main_clr;

    assign in_ready = !flush && (!out_valid || out_ready);
    assign main_clr = flush || (out_valid && out_ready && !accept);

    pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk        (clk),
        .clr_all_i  (reset),
        .clr_ctrl_i (main_clr),
        .load_i     (accept),
        .ctrl_i     (in_ctrl),
        .data_i     (in_data),
        .valid_o    (out_valid),
        .ctrl_o     (out_ctrl),
        .data_o     (out_data)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomised bench for pipe_stage_reg; adapts to PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

    localparam int CW = 12;
    localparam int DW = 135;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID_MODE = 1'b1;
`else
    localparam bit SKID_MODE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;

    int total = 0;
    int bad   = 0;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Apply inputs mid-cycle, then settle 1 time unit before sampling.
    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d, input logic ordy);
        @(negedge clk);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) drive(1'b1, 12'hFFF, 135'h1234, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        total++; if (out_ctrl !== 12'h000) begin bad++; $display("FAIL reset_ctrl got=%h exp=000", out_ctrl); end
        total++; if (out_data !== 135'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_release_valid got=%0b exp=0", out_valid); end
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 12'h0A5, DW'(i), 1'b1);
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready beat=%0d got=%0b exp=1", i, in_ready); end
            if (i == 1) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_first_valid got=%0b exp=0", out_valid); end
            end else begin
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid beat=%0d got=%0b exp=1", i, out_valid); end
                total++; if (out_data !== DW'(i - 1)) begin bad++; $display("FAIL stream_data beat=%0d got=%0d exp=%0d", i, out_data, i - 1); end
                total++; if (out_ctrl !== 12'h0A5) begin bad++; $display("FAIL stream_ctrl beat=%0d got=%h exp=0a5", i, out_ctrl); end
            end
        end
        drive(1'b0, 12'h000, 135'h0, 1'b1);
        total++; if (out_valid !== 1'b1 || out_data !== 135'd8) begin bad++; $display("FAIL stream_last got=%0b/%0d exp=1/8", out_valid, out_data); end
        drive(1'b0, 12'h000, 135'h0, 1'b1);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain_valid got=%0b exp=0", out_valid); end
        total++; if (out_ctrl !== 12'h000) begin bad++; $display("FAIL stream_bubble_ctrl got=%h exp=000", out_ctrl); end
        total++; if (out_data !== 135'd8) begin bad++; $display("FAIL stream_data_hold got=%0d exp=8", out_data); end
    endtask

    task automatic test_stall();
        drive(1'b1, 12'h0A5, 135'h55, 1'b0);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_first_ready got=%0b exp=1", in_ready); end
        drive(1'b1, 12'h0A5, 135'h66, 1'b0);
        total++; if (in_ready !== SKID_MODE) begin bad++; $display("FAIL stall_second_ready got=%0b exp=%0b", in_ready, SKID_MODE); end
        total++; if (out_valid !== 1'b1 || out_data !== 135'h55) begin bad++; $display("FAIL stall_hold0 got=%0b/%h exp=1/55", out_valid, out_data); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 12'h0A5, SKID_MODE ? 135'h99 : 135'h66, 1'b0);
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready cyc=%0d got=%0b exp=0", i, in_ready); end
            total++; if (out_valid !== 1'b1 || out_data !== 135'h55 || out_ctrl !== 12'h0A5) begin
                bad++; $display("FAIL stall_hold cyc=%0d got=%0b/%h/%h exp=1/55/0a5", i, out_valid, out_data, out_ctrl);
            end
        end
        drive(!SKID_MODE, 12'h0A5, 135'h66, 1'b1);
        total++; if (in_ready !== !SKID_MODE) begin bad++; $display("FAIL stall_release_ready got=%0b exp=%0b", in_ready, !SKID_MODE); end
        total++; if (out_valid !== 1'b1 || out_data !== 135'h55) begin bad++; $display("FAIL stall_out55 got=%0b/%h exp=1/55", out_valid, out_data); end
        drive(1'b0, 12'h000, 135'h0, 1'b1);
        total++; if (out_valid !== 1'b1 || out_data !== 135'h66) begin bad++; $display("FAIL stall_out66 got=%0b/%h exp=1/66", out_valid, out_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_after_ready got=%0b exp=1", in_ready); end
        drive(1'b0, 12'h000, 135'h0, 1'b1);
        total++; if (out_valid !== 1'b0 || out_ctrl !== 12'h000) begin bad++; $display("FAIL stall_empty got=%0b/%h exp=0/000", out_valid, out_ctrl); end
    endtask

    task automatic test_flush();
        drive(1'b1, 12'h3FF, 135'h123, 1'b0);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_ctrl = 12'h0A5; in_data = 135'h456; out_ready = 1'b0;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%0b exp=0", in_ready); end
        total++; if (out_valid !== 1'b1 || out_ctrl !== 12'h3FF) begin bad++; $display("FAIL flush_pre got=%0b/%h exp=1/3ff", out_valid, out_ctrl); end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b exp=0", out_valid); end
        total++; if (out_ctrl !== 12'h000) begin bad++; $display("FAIL flush_ctrl got=%h exp=000", out_ctrl); end
        total++; if (out_data !== 135'h123) begin bad++; $display("FAIL flush_data got=%h exp=123", out_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_after_ready got=%0b exp=1", in_ready); end
        drive(1'b0, 12'h000, 135'h0, 1'b1);
        total++; if (out_valid !== 1'b0 || out_data !== 135'h123) begin bad++; $display("FAIL flush_no_accept got=%0b/%h exp=0/123", out_valid, out_data); end
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b1, 12'h0A5, 135'h55, 1'b0);
        drive(1'b1, 12'h0A5, 135'h66, 1'b0);
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b1; in_ctrl = 12'h0A5; in_data = 135'h77; out_ready = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || out_ctrl !== 12'h000 || out_data !== 135'h0) begin
            bad++; $display("FAIL rst_stall_clear got=%0b/%h/%h exp=0/000/0", out_valid, out_ctrl, out_data);
        end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_stall_ready got=%0b exp=1", in_ready); end
        drive(1'b0, 12'h000, 135'h0, 1'b1);
        total++; if (out_valid !== 1'b1 || out_data !== 135'h77 || out_ctrl !== 12'h0A5) begin
            bad++; $display("FAIL rst_stall_77 got=%0b/%h/%h exp=1/77/0a5", out_valid, out_data, out_ctrl);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 12'h000, 135'h0, 1'b1);
            total++; if (out_valid !== 1'b0 || out_ctrl !== 12'h000) begin
                bad++; $display("FAIL rst_stall_stale cyc=%0d got=%0b/%h exp=0/000", i, out_valid, out_data);
            end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] q[$];
        logic [DW-1:0] pd;
        logic          pend;
        logic          exp_rdy;
        int            sent, recv, cyc;
        pend = 1'b0; pd = '0; sent = 0; recv = 0; cyc = 0;
        while (recv < 2000 && cyc < 20000) begin
            @(negedge clk);
            if (!pend && sent < 2000 && $urandom_range(0, 3) != 0) begin
                pend = 1'b1;
                pd = DW'(sent + 1) + (DW'($urandom) << 64);
                sent++;
            end
            in_valid  = pend;
            in_data   = pd;
            in_ctrl   = pd[CW-1:0] | CW'(1);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = SKID_MODE ? (q.size() < 2) : (q.size() == 0 || out_ready);
            total++; if (out_valid !== (q.size() > 0)) begin bad++; $display("FAIL rand_valid cyc=%0d got=%0b exp=%0b", cyc, out_valid, q.size() > 0); end
            total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL rand_ready cyc=%0d got=%0b exp=%0b", cyc, in_ready, exp_rdy); end
            if (!out_valid) begin
                total++; if (out_ctrl !== '0) begin bad++; $display("FAIL rand_bubble_ctrl cyc=%0d got=%h exp=000", cyc, out_ctrl); end
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total++; bad++; $display("FAIL rand_extra cyc=%0d got=%h exp=none", cyc, out_data);
                end else begin
                    total++; if (out_data !== q[0]) begin bad++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, out_data, q[0]); end
                    total++; if (out_ctrl !== (q[0][CW-1:0] | CW'(1))) begin bad++; $display("FAIL rand_ctrl cyc=%0d got=%h exp=%h", cyc, out_ctrl, q[0][CW-1:0] | CW'(1)); end
                    void'(q.pop_front());
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                q.push_back(pd);
                pend = 1'b0;
            end
            cyc++;
        end
        in_valid = 1'b0;
        total++; if (recv != 2000) begin bad++; $display("FAIL rand_count got=%0d exp=2000", recv); end
        total++; if (q.size() != 0) begin bad++; $display("FAIL rand_leftover got=%0d exp=0", q.size()); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_reset_mid_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
